// File: rtl/exp6_unidade_controle_if.sv
// ----------------------------------------------------------------------------
// exp6_unidade_controle_if
//   Bundles the signals exchanged between the memory-game control unit and
//   its datapath (plus start request, result flags and debug state code).
//   master : the control unit - consumes status, drives control strobes.
//   slave  : the datapath side - drives status, consumes control strobes.
//   Signals:
//     iniciar, jogada, igual, enderecoIgualSequencia, fimS, controle_timeout
//       status / request inputs to the control unit
//     zeraE, contaE, zeraS, contaS, zeraR, registraR, zeraT, contaT
//       datapath control strobes
//     pronto, acertou, errou, timeout   result flags
//     db_estado                         current state code (debug)
// ----------------------------------------------------------------------------
interface exp6_unidade_controle_if;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       enderecoIgualSequencia;
    logic       fimS;
    logic       controle_timeout;

    logic       zeraE;
    logic       contaE;
    logic       zeraS;
    logic       contaS;
    logic       zeraR;
    logic       registraR;
    logic       zeraT;
    logic       contaT;

    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, jogada, igual, enderecoIgualSequencia, fimS, controle_timeout,
        output zeraE, contaE, zeraS, contaS, zeraR, registraR, zeraT, contaT,
        output pronto, acertou, errou, timeout, db_estado
    );

    modport slave (
        output iniciar, jogada, igual, enderecoIgualSequencia, fimS, controle_timeout,
        input  zeraE, contaE, zeraS, contaS, zeraR, registraR, zeraT, contaT,
        input  pronto, acertou, errou, timeout, db_estado
    );
endinterface

// File: rtl/exp6_unidade_controle.sv
// ----------------------------------------------------------------------------
// exp6_unidade_controle
//   Moore FSM sequencing the memory-game datapath: clears/increments of the
//   address and sequence-limit counters, button-register load, timeout timer
//   control and round/sequence progression. All outputs decode from the state
//   register only.
//   Ports:
//     clock  : system clock, rising edge
//     reset  : asynchronous, active-low; forces state inicial
//     ctrl   : exp6_unidade_controle_if.master (status in, strobes/flags out)
//   Parameters:
//     HAS_TIMEOUT : 0 ignores controle_timeout (game never ends by timeout)
// ----------------------------------------------------------------------------
module exp6_unidade_controle #(
    parameter bit HAS_TIMEOUT = 1'b1
) (
    input  logic                           clock,
    input  logic                           reset,
    exp6_unidade_controle_if.master        ctrl
);

    localparam logic [3:0] INICIAL           = 4'h0;
    localparam logic [3:0] PREPARACAO        = 4'h1;
    localparam logic [3:0] INICIO_RODADA     = 4'h2;
    localparam logic [3:0] ESPERA_JOGADA     = 4'h3;
    localparam logic [3:0] REGISTRA          = 4'h4;
    localparam logic [3:0] COMPARACAO        = 4'h5;
    localparam logic [3:0] PROXIMO           = 4'h6;
    localparam logic [3:0] PROXIMA_SEQUENCIA = 4'h7;
    localparam logic [3:0] FIM_ACERTOU       = 4'hA;
    localparam logic [3:0] FIM_TIMEOUT       = 4'hD;
    localparam logic [3:0] FIM_ERROU         = 4'hE;

    logic [3:0] estado;
    logic [3:0] proximo_estado;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo_estado;
        end
    end

    // Next-state logic. A jogada pulse outside espera_jogada is simply not
    // looked at, so it is never remembered.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned
        // (which would infer a latch).
        proximo_estado = INICIAL;
        case (estado)
            INICIAL:           proximo_estado = ctrl.iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:        proximo_estado = INICIO_RODADA;
            INICIO_RODADA:     proximo_estado = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // A press wins over a timeout arriving in the same cycle.
                if (ctrl.jogada)
                    proximo_estado = REGISTRA;
                else if (HAS_TIMEOUT && ctrl.controle_timeout)
                    proximo_estado = FIM_TIMEOUT;
                else
                    proximo_estado = ESPERA_JOGADA;
            end
            REGISTRA:          proximo_estado = COMPARACAO;
            COMPARACAO: begin
                if (!ctrl.igual)
                    proximo_estado = FIM_ERROU;
                else if (ctrl.enderecoIgualSequencia && ctrl.fimS)
                    proximo_estado = FIM_ACERTOU;
                else if (ctrl.enderecoIgualSequencia)
                    proximo_estado = PROXIMA_SEQUENCIA;
                else
                    proximo_estado = PROXIMO;
            end
            PROXIMO:           proximo_estado = ESPERA_JOGADA;
            PROXIMA_SEQUENCIA: proximo_estado = INICIO_RODADA;
            FIM_ACERTOU:       proximo_estado = ctrl.iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:         proximo_estado = ctrl.iniciar ? PREPARACAO : FIM_ERROU;
            FIM_TIMEOUT:       proximo_estado = ctrl.iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:           proximo_estado = INICIAL;  // unused codes recover
        endcase
    end

    // Moore output decode. contaT is asserted only while waiting for a press,
    // so the timer freezes while a press is being evaluated.
    always_comb begin
        ctrl.zeraE     = 1'b0;
        ctrl.contaE    = 1'b0;
        ctrl.zeraS     = 1'b0;
        ctrl.contaS    = 1'b0;
        ctrl.zeraR     = 1'b0;
        ctrl.registraR = 1'b0;
        ctrl.zeraT     = 1'b0;
        ctrl.contaT    = 1'b0;
        ctrl.pronto    = 1'b0;
        ctrl.acertou   = 1'b0;
        ctrl.errou     = 1'b0;
        ctrl.timeout   = 1'b0;
        case (estado)
            PREPARACAO: begin
                ctrl.zeraE = 1'b1;
                ctrl.zeraS = 1'b1;
                ctrl.zeraR = 1'b1;
                ctrl.zeraT = 1'b1;
            end
            INICIO_RODADA: begin
                ctrl.zeraE = 1'b1;
                ctrl.zeraT = 1'b1;
            end
            ESPERA_JOGADA:     ctrl.contaT = 1'b1;
            // Loading here lets the button register and the synchronous ROM
            // output both be stable during comparacao.
            REGISTRA:          ctrl.registraR = 1'b1;
            PROXIMO: begin
                ctrl.contaE = 1'b1;
                ctrl.zeraT  = 1'b1;
            end
            PROXIMA_SEQUENCIA: ctrl.contaS = 1'b1;
            FIM_ACERTOU: begin
                ctrl.pronto  = 1'b1;
                ctrl.acertou = 1'b1;
            end
            FIM_ERROU: begin
                ctrl.pronto = 1'b1;
                ctrl.errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                ctrl.pronto  = 1'b1;
                ctrl.errou   = 1'b1;
                ctrl.timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign ctrl.db_estado = estado;

endmodule

// File: tb/tb_exp6_unidade_controle.sv
// ----------------------------------------------------------------------------
// tb_exp6_unidade_controle
//   Directed bench for exp6_unidade_controle. Two instances: dut (timeout
//   enabled) and dut_nt (HAS_TIMEOUT=0). Each step drives the status inputs,
//   takes one rising edge, and compares state code plus all twelve strobes
//   and flags against hand-computed values.
//   Output vector bit order:
//     [11] zeraE [10] contaE [9] zeraS [8] contaS [7] zeraR [6] registraR
//     [5] zeraT [4] contaT [3] pronto [2] acertou [1] errou [0] timeout
// ----------------------------------------------------------------------------
module tb_exp6_unidade_controle;

    // Expected output vectors per state, derived from the state action list.
    localparam logic [11:0] O_INI  = 12'h000;
    localparam logic [11:0] O_PREP = 12'hAA0;  // zeraE zeraS zeraR zeraT
    localparam logic [11:0] O_INIR = 12'h820;  // zeraE zeraT
    localparam logic [11:0] O_ESP  = 12'h010;  // contaT
    localparam logic [11:0] O_REG  = 12'h040;  // registraR
    localparam logic [11:0] O_CMP  = 12'h000;
    localparam logic [11:0] O_PROX = 12'h420;  // contaE zeraT
    localparam logic [11:0] O_PSEQ = 12'h100;  // contaS
    localparam logic [11:0] O_ACE  = 12'h00C;  // pronto acertou
    localparam logic [11:0] O_ERR  = 12'h00A;  // pronto errou
    localparam logic [11:0] O_TMO  = 12'h00B;  // pronto errou timeout

    // One stimulus step: inputs {iniciar, jogada, igual, enderecoIgualSequencia,
    // fimS, controle_timeout}, then expected state and outputs after the edge.
    typedef struct packed {
        logic [5:0]  in;
        logic [3:0]  st;
        logic [11:0] outs;
    } step_t;

    logic clock;
    logic reset;
    int   compared;
    int   mismatched;

    exp6_unidade_controle_if bus ();
    exp6_unidade_controle_if bus_nt ();

    exp6_unidade_controle #(.HAS_TIMEOUT(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .ctrl  (bus)
    );

    exp6_unidade_controle #(.HAS_TIMEOUT(1'b0)) dut_nt (
        .clock (clock),
        .reset (reset),
        .ctrl  (bus_nt)
    );

    logic [11:0] outs_main;
    logic [11:0] outs_nt;
    assign outs_main = {bus.zeraE, bus.contaE, bus.zeraS, bus.contaS, bus.zeraR,
                        bus.registraR, bus.zeraT, bus.contaT, bus.pronto,
                        bus.acertou, bus.errou, bus.timeout};
    assign outs_nt   = {bus_nt.zeraE, bus_nt.contaE, bus_nt.zeraS, bus_nt.contaS,
                        bus_nt.zeraR, bus_nt.registraR, bus_nt.zeraT, bus_nt.contaT,
                        bus_nt.pronto, bus_nt.acertou, bus_nt.errou, bus_nt.timeout};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive inputs of the main instance, take one edge, sample 1 ns later.
    task automatic apply(input logic [5:0] in);
        {bus.iniciar, bus.jogada, bus.igual, bus.enderecoIgualSequencia,
         bus.fimS, bus.controle_timeout} = in;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_nt(input logic [5:0] in);
        {bus_nt.iniciar, bus_nt.jogada, bus_nt.igual, bus_nt.enderecoIgualSequencia,
         bus_nt.fimS, bus_nt.controle_timeout} = in;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        step_t tbl [0:3];
        reset = 1'b0;
        apply(6'b000000);
        apply_nt(6'b000000);
        compared++;
        if ({bus.db_estado, outs_main} !== {4'h0, O_INI}) begin
            mismatched++;
            $display("FAIL reset_initial: got state %h outs %h, expected state 0 outs %h",
                     bus.db_estado, outs_main, O_INI);
        end
        reset = 1'b1;
        // Reach espera_jogada, then drop reset between edges.
        apply(6'b100000);
        apply(6'b000000);
        apply(6'b000000);
        #2 reset = 1'b0;
        #1;
        compared++;
        if ({bus.db_estado, outs_main} !== {4'h0, O_INI}) begin
            mismatched++;
            $display("FAIL reset_async: got state %h outs %h, expected state 0 outs %h",
                     bus.db_estado, outs_main, O_INI);
        end
        #1 reset = 1'b1;
        // iniciar held high in preparacao must be ignored there.
        tbl[0] = {6'b100000, 4'h1, O_PREP};
        tbl[1] = {6'b100000, 4'h2, O_INIR};
        tbl[2] = {6'b000000, 4'h3, O_ESP};
        tbl[3] = {6'b000000, 4'h3, O_ESP};
        foreach (tbl[i]) begin
            apply(tbl[i].in);
            compared++;
            if ({bus.db_estado, outs_main} !== {tbl[i].st, tbl[i].outs}) begin
                mismatched++;
                $display("FAIL reset_start step %0d: got state %h outs %h, expected state %h outs %h",
                         i, bus.db_estado, outs_main, tbl[i].st, tbl[i].outs);
            end
        end
    endtask

    task automatic test_round_end();
        step_t tbl [0:4];
        tbl[0] = {6'b011100, 4'h4, O_REG};
        tbl[1] = {6'b001100, 4'h5, O_CMP};
        tbl[2] = {6'b001100, 4'h7, O_PSEQ};
        tbl[3] = {6'b000000, 4'h2, O_INIR};
        tbl[4] = {6'b000000, 4'h3, O_ESP};
        foreach (tbl[i]) begin
            apply(tbl[i].in);
            compared++;
            if ({bus.db_estado, outs_main} !== {tbl[i].st, tbl[i].outs}) begin
                mismatched++;
                $display("FAIL round_end step %0d: got state %h outs %h, expected state %h outs %h",
                         i, bus.db_estado, outs_main, tbl[i].st, tbl[i].outs);
            end
        end
    endtask

    task automatic test_mid_round();
        step_t tbl [0:3];
        // jogada kept high into registra must not be remembered.
        tbl[0] = {6'b011000, 4'h4, O_REG};
        tbl[1] = {6'b011000, 4'h5, O_CMP};
        tbl[2] = {6'b001000, 4'h6, O_PROX};
        tbl[3] = {6'b000000, 4'h3, O_ESP};
        foreach (tbl[i]) begin
            apply(tbl[i].in);
            compared++;
            if ({bus.db_estado, outs_main} !== {tbl[i].st, tbl[i].outs}) begin
                mismatched++;
                $display("FAIL mid_round step %0d: got state %h outs %h, expected state %h outs %h",
                         i, bus.db_estado, outs_main, tbl[i].st, tbl[i].outs);
            end
        end
    endtask

    task automatic test_timeout_priority();
        step_t tbl [0:3];
        tbl[0] = {6'b011001, 4'h4, O_REG};
        tbl[1] = {6'b001001, 4'h5, O_CMP};
        tbl[2] = {6'b001001, 4'h6, O_PROX};
        tbl[3] = {6'b000000, 4'h3, O_ESP};
        foreach (tbl[i]) begin
            apply(tbl[i].in);
            compared++;
            if ({bus.db_estado, outs_main} !== {tbl[i].st, tbl[i].outs}) begin
                mismatched++;
                $display("FAIL timeout_priority step %0d: got state %h outs %h, expected state %h outs %h",
                         i, bus.db_estado, outs_main, tbl[i].st, tbl[i].outs);
            end
        end
    endtask

    task automatic test_timeout();
        step_t tbl [0:6];
        tbl[0] = {6'b000000, 4'h3, O_ESP};
        tbl[1] = {6'b000001, 4'hD, O_TMO};
        tbl[2] = {6'b010001, 4'hD, O_TMO};
        tbl[3] = {6'b001110, 4'hD, O_TMO};
        tbl[4] = {6'b100000, 4'h1, O_PREP};
        tbl[5] = {6'b000000, 4'h2, O_INIR};
        tbl[6] = {6'b000000, 4'h3, O_ESP};
        foreach (tbl[i]) begin
            apply(tbl[i].in);
            compared++;
            if ({bus.db_estado, outs_main} !== {tbl[i].st, tbl[i].outs}) begin
                mismatched++;
                $display("FAIL timeout step %0d: got state %h outs %h, expected state %h outs %h",
                         i, bus.db_estado, outs_main, tbl[i].st, tbl[i].outs);
            end
        end
    endtask

    task automatic test_wrong_press();
        step_t tbl [0:6];
        tbl[0] = {6'b010100, 4'h4, O_REG};
        tbl[1] = {6'b000100, 4'h5, O_CMP};
        tbl[2] = {6'b000100, 4'hE, O_ERR};
        tbl[3] = {6'b010000, 4'hE, O_ERR};
        tbl[4] = {6'b000001, 4'hE, O_ERR};
        tbl[5] = {6'b100000, 4'h1, O_PREP};
        tbl[6] = {6'b000000, 4'h2, O_INIR};
        foreach (tbl[i]) begin
            apply(tbl[i].in);
            compared++;
            if ({bus.db_estado, outs_main} !== {tbl[i].st, tbl[i].outs}) begin
                mismatched++;
                $display("FAIL wrong_press step %0d: got state %h outs %h, expected state %h outs %h",
                         i, bus.db_estado, outs_main, tbl[i].st, tbl[i].outs);
            end
        end
    endtask

    task automatic test_win();
        step_t tbl [0:8];
        tbl[0] = {6'b000000, 4'h3, O_ESP};
        tbl[1] = {6'b011110, 4'h4, O_REG};
        tbl[2] = {6'b001110, 4'h5, O_CMP};
        tbl[3] = {6'b001110, 4'hA, O_ACE};
        tbl[4] = {6'b010000, 4'hA, O_ACE};
        tbl[5] = {6'b000001, 4'hA, O_ACE};
        tbl[6] = {6'b000000, 4'hA, O_ACE};
        tbl[7] = {6'b100000, 4'h1, O_PREP};
        tbl[8] = {6'b000000, 4'h2, O_INIR};
        foreach (tbl[i]) begin
            apply(tbl[i].in);
            compared++;
            if ({bus.db_estado, outs_main} !== {tbl[i].st, tbl[i].outs}) begin
                mismatched++;
                $display("FAIL win step %0d: got state %h outs %h, expected state %h outs %h",
                         i, bus.db_estado, outs_main, tbl[i].st, tbl[i].outs);
            end
        end
    endtask

    task automatic test_no_timeout();
        step_t tbl [0:6];
        tbl[0] = {6'b100000, 4'h1, O_PREP};
        tbl[1] = {6'b000000, 4'h2, O_INIR};
        tbl[2] = {6'b000000, 4'h3, O_ESP};
        tbl[3] = {6'b000001, 4'h3, O_ESP};
        tbl[4] = {6'b000001, 4'h3, O_ESP};
        tbl[5] = {6'b011001, 4'h4, O_REG};
        tbl[6] = {6'b001001, 4'h5, O_CMP};
        foreach (tbl[i]) begin
            apply_nt(tbl[i].in);
            compared++;
            if ({bus_nt.db_estado, outs_nt} !== {tbl[i].st, tbl[i].outs}) begin
                mismatched++;
                $display("FAIL no_timeout step %0d: got state %h outs %h, expected state %h outs %h",
                         i, bus_nt.db_estado, outs_nt, tbl[i].st, tbl[i].outs);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        {bus.iniciar, bus.jogada, bus.igual, bus.enderecoIgualSequencia,
         bus.fimS, bus.controle_timeout} = 6'b000000;
        {bus_nt.iniciar, bus_nt.jogada, bus_nt.igual, bus_nt.enderecoIgualSequencia,
         bus_nt.fimS, bus_nt.controle_timeout} = 6'b000000;

        test_reset();             // ends in state 3
        test_round_end();         // ends in state 3
        test_mid_round();         // ends in state 3
        test_timeout_priority();  // ends in state 3
        test_timeout();           // ends in state 3
        test_wrong_press();       // ends in state 2
        test_win();               // ends in state 2
        test_no_timeout();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
